// File: rtl/countdown_ctrl.sv
// countdown_ctrl: start/pause/tick front end for the 15-bit loadable up/down
// counter. Loads the counter from a preset on a start press, counts it down
// one step per tick while running, and flags when it reaches zero.
//
// Counter strobe protocol: cnt_ld and cnt_dw are single-cycle strobes that
// the counter consumes on the same rising edge. They are mutually exclusive.
// cnt_din is valid whenever cnt_ld is high. cnt_dw is never raised while
// cnt_dtc is high, so the counter cannot wrap below zero.
module countdown_ctrl #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_btn,
  input  logic             pause_btn,
  input  logic             tick,
  input  logic [WIDTH-1:0] preset,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cnt_dtc,
  output logic             cnt_ld,
  output logic [WIDTH-1:0] cnt_din,
  output logic             cnt_up,
  output logic             cnt_dw,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             expire_pulse,
  output logic [WIDTH-1:0] remaining,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    RUN    = 3'd3,
    PAUSED = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic start_s1, start_s2, start_s3;
  logic pause_s1, pause_s2, pause_s3;
  logic start_edge;
  logic pause_edge;

  logic [WIDTH-1:0] load_val;

  // Two-flop synchronizers plus a third flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
      pause_s1 <= 1'b0;
      pause_s2 <= 1'b0;
      pause_s3 <= 1'b0;
    end else begin
      start_s1 <= start_btn;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      pause_s1 <= pause_btn;
      pause_s2 <= pause_s1;
      pause_s3 <= pause_s2;
    end
  end

  assign start_edge = start_s2 & ~start_s3;
  assign pause_edge = pause_s2 & ~pause_s3;

  // Capture the preset on every start press; it feeds the counter load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_val <= '0;
    end else if (start_edge) begin
      load_val <= preset;
    end
  end

  // Registered status copy of the counter value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
    end else begin
      remaining <= cnt_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. In RUN, reaching zero outranks a restart or pause.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_edge) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        // Counter has just been loaded; a zero preset finishes immediately.
        if (cnt_dtc) state_nxt = DONE;
        else         state_nxt = RUN;
      end
      RUN: begin
        if (cnt_dtc)         state_nxt = DONE;
        else if (start_edge) state_nxt = LOAD;
        else if (pause_edge) state_nxt = PAUSED;
      end
      PAUSED: begin
        if (start_edge)      state_nxt = LOAD;
        else if (pause_edge) state_nxt = RUN;
      end
      DONE: begin
        if (start_edge) state_nxt = LOAD;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode. Outputs depend on the state register, so an async reset
  // clears them without waiting for a clock edge.
  always_comb begin
    cnt_ld  = 1'b0;
    cnt_dw  = 1'b0;
    running = 1'b0;
    paused  = 1'b0;
    expired = 1'b0;
    unique case (state)
      LOAD: begin
        cnt_ld = 1'b1;
      end
      RUN: begin
        running = 1'b1;
        cnt_dw  = tick & ~cnt_dtc;
      end
      PAUSED: begin
        paused = 1'b1;
      end
      DONE: begin
        expired = 1'b1;
      end
      default: begin
        cnt_ld = 1'b0;
      end
    endcase
  end

  // One-cycle pulse in the first cycle spent in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expire_pulse <= 1'b0;
    end else begin
      expire_pulse <= ((state == RUN) || (state == CHECK)) && (state_nxt == DONE);
    end
  end

  assign cnt_din   = load_val;
  assign cnt_up    = 1'b0;
  assign dbg_state = state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: drives buttons and ticks and models the
// downstream counter. Load data is scoreboarded against presets, and
// per-run strobe counts are compared against a vector table.
module tb_countdown_ctrl;

  localparam int W = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_btn = 1'b0;
  logic         pause_btn = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] preset = '0;
  logic [W-1:0] cnt_q = 15'h1234;
  logic         cnt_dtc;
  logic         cnt_ld;
  logic [W-1:0] cnt_din;
  logic         cnt_up;
  logic         cnt_dw;
  logic         running;
  logic         paused;
  logic         expired;
  logic         expire_pulse;
  logic [W-1:0] remaining;
  logic [2:0]   dbg_state;

  countdown_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .tick         (tick),
    .preset       (preset),
    .cnt_q        (cnt_q),
    .cnt_dtc      (cnt_dtc),
    .cnt_ld       (cnt_ld),
    .cnt_din      (cnt_din),
    .cnt_up       (cnt_up),
    .cnt_dw       (cnt_dw),
    .running      (running),
    .paused       (paused),
    .expired      (expired),
    .expire_pulse (expire_pulse),
    .remaining    (remaining),
    .dbg_state    (dbg_state)
  );

  // Downstream counter: load has priority, then up, then down. No reset.
  always @(posedge clk) begin
    if (cnt_ld)      cnt_q <= cnt_din;
    else if (cnt_up) cnt_q <= cnt_q + 15'd1;
    else if (cnt_dw) cnt_q <= cnt_q - 15'd1;
  end
  assign cnt_dtc = (cnt_q == '0);

  // ---------------- scoreboard / counters ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ld_count = 0;
  int dw_count = 0;
  int pulse_count = 0;

  typedef struct {
    logic [W-1:0] preset;
    int           pause_after;
    int           pause_ticks;
    logic [W-1:0] exp_hold;
    int           exp_dw;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic flag_of(input int sel);
    case (sel)
      0:       return running;
      1:       return paused;
      2:       return expired;
      default: return running | expired;
    endcase
  endfunction

  // Observes the DUT every cycle on the falling edge.
  task automatic monitor();
    logic         prev_exp = 1'b0;
    logic         prev_pulse = 1'b0;
    logic         prev_rst = 1'b0;
    logic [W-1:0] prev_q = '0;
    forever begin
      @(negedge clk);
      if (cnt_ld) begin
        ld_count++;
        chk("ld_sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk("ld_din", {17'd0, cnt_din}, {17'd0, exp_q.pop_front()});
        chk("ld_dw_excl", {31'd0, cnt_dw}, 32'd0);
      end
      if (cnt_dw) begin
        dw_count++;
        chk("no_wrap", {31'd0, cnt_q != '0}, 32'd1);
      end
      if (expire_pulse) begin
        pulse_count++;
        chk("pulse_entry", {31'd0, prev_exp}, 32'd0);
        chk("pulse_level", {31'd0, expired}, 32'd1);
        chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
      end
      if (rst_n && prev_rst) chk("remaining", {17'd0, remaining}, {17'd0, prev_q});
      prev_exp   = expired;
      prev_pulse = expire_pulse;
      prev_rst   = rst_n;
      prev_q     = cnt_q;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic press(input logic do_start, input logic do_pause);
    @(posedge clk); #1;
    if (do_start) exp_q.push_back(preset);
    start_btn = do_start;
    pause_btn = do_pause;
    repeat (2) @(posedge clk);
    #1;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic wait_for(input string name, input int sel, input int budget);
    int n = 0;
    while (!flag_of(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, flag_of(sel)}, 32'd1);
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (!expired && n < budget) begin
      do_ticks(1);
      n++;
    end
    @(negedge clk);
    chk("reach_done", {31'd0, expired}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_flags"}, {25'd0, cnt_ld, cnt_dw, cnt_up, running, paused, expired, expire_pulse}, 32'd0);
    chk({name, "_state"}, {29'd0, dbg_state}, 32'd0);
    chk({name, "_rem"}, {17'd0, remaining}, 32'd0);
    chk({name, "_din"}, {17'd0, cnt_din}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int ld0 = ld_count;
    int dw0 = dw_count;
    int p0  = pulse_count;
    preset = v.preset;
    press(1'b1, 1'b0);
    wait_for("active", 4, 20);
    if (v.pause_after > 0) begin
      do_ticks(v.pause_after);
      press(1'b0, 1'b1);
      wait_for("paused", 1, 20);
      do_ticks(v.pause_ticks);
      chk("hold_q", {17'd0, cnt_q}, {17'd0, v.exp_hold});
      chk("hold_rem", {17'd0, remaining}, {17'd0, v.exp_hold});
      chk("hold_paused", {31'd0, paused}, 32'd1);
      press(1'b0, 1'b1);
      wait_for("resumed", 0, 20);
    end
    run_to_done(200);
    do_ticks(2);
    chk("vec_ld", ld_count - ld0, 32'd1);
    chk("vec_dw", dw_count - dw0, v.exp_dw);
    chk("vec_pulse", pulse_count - p0, 32'd1);
    chk("vec_q0", {17'd0, cnt_q}, 32'd0);
    chk("vec_rem0", {17'd0, remaining}, 32'd0);
    chk("vec_expired", {31'd0, expired}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ld0;
    int dw0;
    int p0;
    int rp;
    int ra;

    rp = $urandom_range(2, 30);
    ra = $urandom_range(1, rp - 1);
    vecs[0] = '{preset: 15'd5,  pause_after: 0,  pause_ticks: 0,  exp_hold: 15'd0,  exp_dw: 5};
    vecs[1] = '{preset: 15'd0,  pause_after: 0,  pause_ticks: 0,  exp_hold: 15'd0,  exp_dw: 0};
    vecs[2] = '{preset: 15'd10, pause_after: 3,  pause_ticks: 20, exp_hold: 15'd7,  exp_dw: 10};
    vecs[3] = '{preset: 15'd1,  pause_after: 0,  pause_ticks: 0,  exp_hold: 15'd0,  exp_dw: 1};
    vecs[4] = '{preset: 15'd12, pause_after: 5,  pause_ticks: 4,  exp_hold: 15'd7,  exp_dw: 12};
    vecs[5] = '{preset: W'(rp), pause_after: ra, pause_ticks: 3,  exp_hold: W'(rp - ra), exp_dw: rp};

    fork
      monitor();
    join_none

    // Reset with tick every 4 cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tick = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (2) @(posedge clk);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Tick arriving while RUN already sees Q = 0 must not decrement.
    dw0 = dw_count;
    preset = 15'd1;
    press(1'b1, 1'b0);
    wait_for("guard_active", 0, 20);
    @(posedge clk); #1;
    tick = 1'b1;
    @(negedge clk);
    chk("guard_dw_first", {31'd0, cnt_dw}, 32'd1);
    @(negedge clk);
    chk("guard_dw_gated", {31'd0, cnt_dw}, 32'd0);
    chk("guard_still_run", {31'd0, running}, 32'd1);
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    chk("guard_done", {31'd0, expired}, 32'd1);
    chk("guard_no_max", {31'd0, cnt_q == 15'h7FFF}, 32'd0);
    chk("guard_dw_count", dw_count - dw0, 32'd1);

    // Restart mid-count reloads the counter.
    ld0 = ld_count; dw0 = dw_count; p0 = pulse_count;
    preset = 15'd100;
    press(1'b1, 1'b0);
    wait_for("restart_active", 0, 20);
    do_ticks(10);
    chk("restart_q90", {17'd0, cnt_q}, 32'd90);
    preset = 15'd20;
    press(1'b1, 1'b0);
    chk("restart_q20", {17'd0, cnt_q}, 32'd20);
    chk("restart_run", {31'd0, running}, 32'd1);
    run_to_done(200);
    chk("restart_ld", ld_count - ld0, 32'd2);
    chk("restart_dw", dw_count - dw0, 32'd30);
    chk("restart_pulse", pulse_count - p0, 32'd1);

    // Tick in the same cycle as the pause edge: decrement, then pause.
    dw0 = dw_count;
    preset = 15'd8;
    press(1'b1, 1'b0);
    wait_for("tp_active", 0, 20);
    do_ticks(2);
    @(posedge clk); #1;
    pause_btn = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    pause_btn = 1'b0;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("tp_paused", {31'd0, paused}, 32'd1);
    chk("tp_q5", {17'd0, cnt_q}, 32'd5);
    do_ticks(2);
    chk("tp_hold", {17'd0, cnt_q}, 32'd5);
    press(1'b0, 1'b1);
    wait_for("tp_resumed", 0, 20);
    run_to_done(200);
    chk("tp_dw", dw_count - dw0, 32'd8);

    // Simultaneous start and pause: start wins.
    dw0 = dw_count;
    preset = 15'd9;
    press(1'b1, 1'b0);
    wait_for("sp_active", 0, 20);
    do_ticks(2);
    preset = 15'd4;
    press(1'b1, 1'b1);
    chk("sp_running", {31'd0, running}, 32'd1);
    chk("sp_not_paused", {31'd0, paused}, 32'd0);
    chk("sp_q4", {17'd0, cnt_q}, 32'd4);
    run_to_done(200);
    chk("sp_dw", dw_count - dw0, 32'd6);

    // Async reset in RUN at Q = 37.
    preset = 15'd40;
    press(1'b1, 1'b0);
    wait_for("ar_active", 0, 20);
    do_ticks(3);
    chk("ar_q37", {17'd0, cnt_q}, 32'd37);
    @(posedge clk); #3;
    rst_n = 1'b0;
    tick = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ld0 = ld_count; dw0 = dw_count;
    do_ticks(5);
    chk("ar_no_dw", dw_count - dw0, 32'd0);
    chk("ar_no_ld", ld_count - ld0, 32'd0);
    chk("ar_q_kept", {17'd0, cnt_q}, 32'd37);
    chk("ar_idle", {29'd0, dbg_state}, 32'd0);

    chk("sb_empty", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
